rx_framer_mc: RTL
=================

Name: rx_framer_mc

Overview:
Multi-channel, parametrised successor of the single-channel RX framer. Drains NUM_CH first-word-fall-through sample FIFOs (one per LVDS RX channel) and selects a channel round-robin at frame boundaries. Each frame is emitted into the shared host FIFO as: header, timestamp MSB, timestamp LSB, runtime-length payload, FCS. Sits between the per-channel RX sample FIFOs and the SMI/host-side TX FIFO.

Parameters:
NUM_CH, 2, number of input channels (1..8)
LEN_W, 10, width of cfg_len; max payload length 2^LEN_W-1 words
TS_INC, 250, per-sample timestamp increment (64-bit, per channel)
SYNC_WORD, 16'hCAFE, header tag, bits [31:16]
FCS_TAG, 16'hC0DE, FCS tag, bits [31:16]

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  start new frames while high
i_cfg_len  in  LEN_W  payload words per frame, sampled at frame start; 0 treated as 1
i_empty  in  NUM_CH  per-channel FIFO empty
i_data  in  32*NUM_CH  per-channel FWFT data; channel c at [32c+31:32c]
o_read  out  NUM_CH  per-channel read strobe; combinational
i_fifo_full  in  1  output FIFO full
o_fifo_push  out  1  output write strobe
o_fifo_data  out  32  output word
o_busy  out  1  high while a frame is in progress (any state except IDLE)
o_frame_cnt  out  32  completed frames, all channels, wraps

Behaviour:
- Reset values: o_fifo_push=0, o_fifo_data=0, o_frame_cnt=0, o_busy=0; all per-channel seq=0 and ts=0; state=IDLE; last_ch=NUM_CH-1, so channel 0 is served first.
- States: IDLE, HEADER, TS_MSB, TS_LSB, PAYLOAD, FCS.
- Output is registered. A word is pushed on the cycle after the state that produces it. o_fifo_push is high for exactly one cycle per word.
- Stall: while i_fifo_full=1, the state, counters and CRC all hold, o_read=0 and o_fifo_push=0 the next cycle. i_fifo_full dominates every other event.
- IDLE: when i_enable=1, search channels last_ch+1 .. last_ch+NUM_CH (mod NUM_CH). The first channel with i_empty[c]=0 becomes sel and last_ch. On that same cycle, latch len=max(i_cfg_len,1)-1 and crc=16'hFFFF, then go to HEADER. If no channel is ready, stay in IDLE.
- HEADER: push {SYNC_WORD, sel[2:0], seq[sel][12:0]}; seq[sel] increments and wraps at 13 bits. Go to TS_MSB.
- TS_MSB: push ts[sel][63:32]. Go to TS_LSB.
- TS_LSB: push ts[sel][31:0]. Go to PAYLOAD. The pushed timestamp is the one belonging to the first payload sample.
- PAYLOAD:
  - o_read[sel] = (state==PAYLOAD) & ~i_fifo_full & ~i_empty[sel]; all other bits of o_read are 0.
  - On a read: push i_data[sel]; crc=crc16_ccitt(crc, word); ts[sel]+=TS_INC.
  - If len==0, go to FCS; otherwise len decrements.
  - If i_empty[sel]=1: no push, hold in PAYLOAD. Underrun does not abort the frame.
- FCS: push {FCS_TAG, crc}; o_frame_cnt increments; go to IDLE.
- CRC: polynomial 0x1021, init 0xFFFF, no reflection, no final XOR. The 32-bit word is processed in a single step, MSB-first, over payload words only.
- Deasserting i_enable mid-frame has no effect; the frame completes and the block then stays in IDLE.
- Changing i_cfg_len mid-frame has no effect on the current frame.
- Reset mid-frame: the frame is aborted, no FCS is emitted, and all reset values apply on the next cycle.
- Timestamps of non-selected channels do not advance.

Decomposition:
- Package rx_framer_pkg holds:
  - the state encoding constants;
  - the SYNC_WORD and FCS_TAG defaults;
  - the crc16_ccitt_w32(crc_in[15:0], data[31:0]) function, shared with the existing framer.
- Sub-module rx_rr_arbiter (parameter NUM_CH):
  - inputs: req=~i_empty, last_ch;
  - outputs: grant_valid, grant_idx;
  - purely combinational priority rotate.

Test Plan:
- NUM_CH=2, cfg_len=4, ch0 FIFO holds 1,2,3,4, ch1 empty -> pushes CAFE0000, 00000000, 00000000, 1, 2, 3, 4, C0DE_xxxx with crc equal to the model value; then idle; o_frame_cnt=1.
- Both channels always non-empty, cfg_len=2, 4 frames -> channel order 0,1,0,1; ch0 headers have seq 0 then 1; ch0 second TS_LSB equals 500.
- i_fifo_full pulsed for 3 cycles during TS_MSB and mid-PAYLOAD -> no push and no o_read while full; word sequence identical to the unstalled run.
- ch0 empties after 2 of 4 payload words, refills 10 cycles later -> frame pauses without pushes, then completes with 4 payload words and a correct FCS.
- i_reset asserted on payload word 3 of 8 -> next cycle push=0, state IDLE; following frame header seq=0, TS=0.
- i_enable dropped during HEADER; cfg_len=0 on the next frame -> the current frame completes, then no new frame starts; after re-enable, the next frame carries exactly 1 payload word.

Source files
------------

// File: rtl/rx_framer_mc_pkg.sv
// rx_framer_pkg: definitions shared by the RX framer family.
//   state_e          - framer FSM state encoding
//   SYNC_WORD_DEF    - default header tag (header bits [31:16])
//   FCS_TAG_DEF      - default FCS tag (FCS word bits [31:16])
//   crc16_ccitt_w32  - CRC-16/CCITT (poly 0x1021, no reflection) over one
//                      32-bit word, MSB first, in a single step
package rx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_TS_MSB  = 3'd2,
        ST_TS_LSB  = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_FCS     = 3'd5
    } state_e;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hCAFE;
    localparam logic [15:0] FCS_TAG_DEF   = 16'hC0DE;

    function automatic logic [15:0] crc16_ccitt_w32(input logic [15:0] crc_in,
                                                    input logic [31:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_framer_mc_if.sv
// rx_framer_mc_if: host-side FIFO write bus.
//   fifo_push - one-cycle write strobe per word (framer -> FIFO)
//   fifo_data - 32-bit word written with fifo_push (framer -> FIFO)
//   fifo_full - FIFO cannot accept a word (FIFO -> framer)
interface rx_framer_mc_if;
    logic        fifo_push;
    logic [31:0] fifo_data;
    logic        fifo_full;

    modport master (output fifo_push, output fifo_data, input fifo_full);
    modport slave  (input fifo_push, input fifo_data, output fifo_full);
endinterface

// File: rtl/rx_framer_mc_rr_arbiter.sv
// rx_rr_arbiter: combinational round-robin pick.
//   req_i         - per-channel request (channel FIFO non-empty)
//   last_ch_i     - channel served last; search starts one above it
//   grant_valid_o - some channel is requesting
//   grant_idx_o   - first requesting channel after last_ch_i, wrapping
module rx_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_ch_i,
    output logic              grant_valid_o,
    output logic [CH_W-1:0]   grant_idx_o
);
    logic [CH_W-1:0] idx;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(last_ch_i) + i) % NUM_CH);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end
endmodule

// File: rtl/rx_framer_mc.sv
// rx_framer_mc: drains NUM_CH FWFT sample FIFOs round-robin into one host
// FIFO as frames of header, TS MSB, TS LSB, payload, FCS.
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_enable       - allow new frames to start
//   i_cfg_len      - payload words per frame (0 means 1), latched at start
//   i_empty/i_data - per-channel FIFO status and FWFT data
//   o_read         - per-channel read strobe (combinational)
//   host           - host FIFO write bus (master side)
//   o_busy         - frame in progress
//   o_frame_cnt    - completed frames, all channels
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for enable and a non-empty channel
// ST_HEADER  | push sync word, channel and sequence number
// ST_TS_MSB  | push timestamp bits [63:32]
// ST_TS_LSB  | push timestamp bits [31:0]
// ST_PAYLOAD | forward samples, update CRC and timestamp
// ST_FCS     | push FCS tag and CRC, count the frame
module rx_framer_mc
    import rx_framer_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          LEN_W     = 10,
    parameter logic [63:0] TS_INC    = 64'd250,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter logic [15:0] FCS_TAG   = FCS_TAG_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [LEN_W-1:0]     i_cfg_len,
    input  logic [NUM_CH-1:0]    i_empty,
    input  logic [32*NUM_CH-1:0] i_data,
    output logic [NUM_CH-1:0]    o_read,
    rx_framer_mc_if.master       host,
    output logic                 o_busy,
    output logic [31:0]          o_frame_cnt
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e          state_q;
    logic [CH_W-1:0] sel_q;
    logic [CH_W-1:0] last_ch_q;
    logic [LEN_W-1:0] len_q;
    logic [15:0]     crc_q;
    logic            push_q;
    logic [31:0]     data_q;
    logic [31:0]     frame_cnt_q;
    logic [12:0]     seq_q [NUM_CH];
    logic [63:0]     ts_q  [NUM_CH];

    logic            grant_valid;
    logic [CH_W-1:0] grant_idx;
    logic [31:0]     word_sel;
    logic [15:0]     crc_d;
    logic [LEN_W-1:0] len_d;

    rx_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
        .req_i         (~i_empty),
        .last_ch_i     (last_ch_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign word_sel = i_data[32*sel_q +: 32];
    assign crc_d    = crc16_ccitt_w32(crc_q, word_sel);
    assign len_d    = (i_cfg_len == '0) ? '0 : i_cfg_len - LEN_W'(1);

    always_comb begin
        o_read = '0;
        if (state_q == ST_PAYLOAD && !host.fifo_full && !i_empty[sel_q])
            o_read[sel_q] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            last_ch_q   <= CH_W'(NUM_CH - 1);
            len_q       <= '0;
            crc_q       <= 16'hFFFF;
            push_q      <= 1'b0;
            data_q      <= '0;
            frame_cnt_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                seq_q[c] <= '0;
                ts_q[c]  <= '0;
            end
        end else if (host.fifo_full) begin
            // Back-pressure freezes everything; only the strobe is dropped.
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_enable && grant_valid) begin
                        sel_q     <= grant_idx;
                        last_ch_q <= grant_idx;
                        len_q     <= len_d;
                        crc_q     <= 16'hFFFF;
                        state_q   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    push_q        <= 1'b1;
                    data_q        <= {SYNC_WORD, 3'(sel_q), seq_q[sel_q]};
                    seq_q[sel_q]  <= seq_q[sel_q] + 13'd1;
                    state_q       <= ST_TS_MSB;
                end
                ST_TS_MSB: begin
                    push_q  <= 1'b1;
                    data_q  <= ts_q[sel_q][63:32];
                    state_q <= ST_TS_LSB;
                end
                ST_TS_LSB: begin
                    push_q  <= 1'b1;
                    data_q  <= ts_q[sel_q][31:0];
                    state_q <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    // An empty channel just pauses the frame.
                    if (!i_empty[sel_q]) begin
                        push_q      <= 1'b1;
                        data_q      <= word_sel;
                        crc_q       <= crc_d;
                        ts_q[sel_q] <= ts_q[sel_q] + TS_INC;
                        if (len_q == '0) state_q <= ST_FCS;
                        else             len_q   <= len_q - LEN_W'(1);
                    end
                end
                ST_FCS: begin
                    push_q      <= 1'b1;
                    data_q      <= {FCS_TAG, crc_q};
                    frame_cnt_q <= frame_cnt_q + 32'd1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign host.fifo_push = push_q;
    assign host.fifo_data = data_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_frame_cnt    = frame_cnt_q;
endmodule
